rt_eoc_monitor: RTL

Parametrised end-of-computation monitor for RT-SS test and bring-up. Collects per-hart exit codes written over a memory-mapped OBI-style slave port, with bit 31 marking done and bits 30:0 carrying the code. It raises pass/fail/timeout flags and an interrupt once all enabled channels finish or a heartbeat watchdog expires. It replaces host-side polling of a single debug data register with an on-chip, multi-channel collector.

---
 rtl/rt_eoc_monitor.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rt_eoc_monitor.sv
// rt_eoc_monitor: multi-channel end-of-computation collector behind an OBI-style slave port.
// Define RT_EOC_MON_WATCHDOG_EN to build the heartbeat watchdog and the TIMEOUT state.
module rt_eoc_monitor #(
   parameter int unsigned NumCh    = 4,
   parameter int unsigned TimeoutW = 32,
   parameter int unsigned AddrW    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [AddrW-1:0]    addr_i,
   input  logic [31:0]         wdata_i,
   output logic                gnt_o,
   output logic                rvalid_o,
   output logic [31:0]         rdata_o,
   output logic                err_o,
   input  logic [TimeoutW-1:0] timeout_cycles_i,
   output logic [NumCh-1:0]    ch_done_o,
   output logic                eoc_o,
   output logic                pass_o,
   output logic                fail_o,
   output logic                timeout_o,
   output logic                irq_o
);

   localparam int unsigned WaW = AddrW - 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      DONE    = 2'd2,
      TIMEOUT = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [NumCh-1:0] mask_q, mask_d;
   logic [NumCh-1:0] done_q, done_d;
   logic [31:0]      code_q [NumCh];
   logic [31:0]      code_d [NumCh];
   logic [31:0]      cycles_q, cycles_d;
   logic             eoc_q, eoc_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
   logic             irq_q, irq_d;
   logic             rvalid_q, rvalid_d;
   logic             err_q, err_d;
   logic [31:0]      rdata_q, rdata_d;

`ifdef RT_EOC_MON_WATCHDOG_EN
   logic [TimeoutW-1:0] wdog_q, wdog_d;
   logic                tmo_q, tmo_d;
   logic                heartbeat;
   logic                wdog_hit;
`else
   logic                unused_timeout;
`endif

   // address decode
   logic [WaW-1:0]   wa;
   logic             aligned;
   logic [NumCh-1:0] ch_sel;
   logic             is_exit, is_ctrl, is_status, is_cycles, addr_ok;
   logic [31:0]      rd_word;
   logic             start_req, clear_req, codes_ok;

   always_comb begin
      wa        = addr_i[AddrW-1:2];
      aligned   = (addr_i[1:0] == 2'b00);
      for (int unsigned i = 0; i < NumCh; i++) begin
         ch_sel[i] = aligned && (wa == WaW'(i));
      end
      is_exit   = |ch_sel;
      is_ctrl   = aligned && (wa == WaW'(16));
      is_status = aligned && (wa == WaW'(17));
      is_cycles = aligned && (wa == WaW'(18));
      addr_ok   = is_exit | is_ctrl | is_status | is_cycles;
   end

   always_comb begin
      rd_word = '0;
      for (int unsigned i = 0; i < NumCh; i++) begin
         if (ch_sel[i]) begin
            rd_word = code_q[i];
         end
      end
      if (is_ctrl) begin
         rd_word[8 +: NumCh] = mask_q;
      end
      if (is_status) begin
         rd_word[NumCh-1:0] = done_q;
         rd_word[16]        = eoc_q;
         rd_word[17]        = pass_q;
         rd_word[18]        = fail_q;
         rd_word[19]        = timeout_o;
         rd_word[21:20]     = state_q;
      end
      if (is_cycles) begin
         rd_word = cycles_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      done_d    = done_q;
      code_d    = code_q;
      cycles_d  = cycles_q;
      eoc_d     = eoc_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      irq_d     = 1'b0;
      rvalid_d  = req_i;
      rdata_d   = '0;
      err_d     = 1'b0;
      start_req = 1'b0;
      clear_req = 1'b0;
      codes_ok  = 1'b1;
`ifdef RT_EOC_MON_WATCHDOG_EN
      wdog_d    = wdog_q;
      tmo_d     = tmo_q;
      heartbeat = 1'b0;
      wdog_hit  = 1'b0;
`endif

      if (req_i) begin
         if (!addr_ok) begin
            err_d = 1'b1;
         end else if (!we_i) begin
            rdata_d = rd_word;
         end else if (is_ctrl) begin
            mask_d    = wdata_i[8 +: NumCh];
            start_req = wdata_i[0];
            clear_req = wdata_i[1];
         end else if (!is_exit) begin
            err_d = 1'b1;
         end else if (state_q != RUN) begin
            err_d = 1'b1;
         end else if (!wdata_i[31]) begin
`ifdef RT_EOC_MON_WATCHDOG_EN
            heartbeat = 1'b1;
`endif
         end else if ((done_q & ch_sel) != '0) begin
            err_d = 1'b1;
         end else begin
            done_d = done_q | ch_sel;
            for (int unsigned i = 0; i < NumCh; i++) begin
               if (ch_sel[i]) begin
                  code_d[i] = wdata_i;
               end
            end
         end
      end

      for (int unsigned i = 0; i < NumCh; i++) begin
         if (mask_d[i] && (code_d[i][30:0] != '0)) begin
            codes_ok = 1'b0;
         end
      end

      // Completion is judged on this cycle's write so DONE lands with the done bit.
      case (state_q)
         IDLE: begin
            if (start_req) begin
               state_d  = RUN;
               done_d   = '0;
               cycles_d = '0;
               for (int unsigned i = 0; i < NumCh; i++) begin
                  code_d[i] = '0;
               end
`ifdef RT_EOC_MON_WATCHDOG_EN
               wdog_d   = '0;
`endif
            end
         end
         RUN: begin
            cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;
`ifdef RT_EOC_MON_WATCHDOG_EN
            if (heartbeat) begin
               wdog_d = '0;
            end else begin
               wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + TimeoutW'(1);
            end
            wdog_hit = (timeout_cycles_i != '0) && (wdog_d == timeout_cycles_i);
`endif
            if ((done_d & mask_d) == mask_d) begin
               state_d = DONE;
               eoc_d   = 1'b1;
               pass_d  = codes_ok;
               fail_d  = !codes_ok;
               irq_d   = 1'b1;
            end
`ifdef RT_EOC_MON_WATCHDOG_EN
            else if (wdog_hit) begin
               state_d = TIMEOUT;
               eoc_d   = 1'b1;
               pass_d  = 1'b0;
               fail_d  = 1'b1;
               tmo_d   = 1'b1;
               irq_d   = 1'b1;
            end
`endif
         end
         default: ;
      endcase

      if (clear_req) begin
         state_d  = IDLE;
         done_d   = '0;
         cycles_d = '0;
         eoc_d    = 1'b0;
         pass_d   = 1'b0;
         fail_d   = 1'b0;
         irq_d    = 1'b0;
         for (int unsigned i = 0; i < NumCh; i++) begin
            code_d[i] = '0;
         end
`ifdef RT_EOC_MON_WATCHDOG_EN
         wdog_d   = '0;
         tmo_d    = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mask_q   <= '1;
         done_q   <= '0;
         for (int unsigned i = 0; i < NumCh; i++) begin
            code_q[i] <= '0;
         end
         cycles_q <= '0;
         eoc_q    <= 1'b0;
         pass_q   <= 1'b0;
         fail_q   <= 1'b0;
         irq_q    <= 1'b0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         done_q   <= done_d;
         code_q   <= code_d;
         cycles_q <= cycles_d;
         eoc_q    <= eoc_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
         irq_q    <= irq_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

`ifdef RT_EOC_MON_WATCHDOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_q <= '0;
         tmo_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         tmo_q  <= tmo_d;
      end
   end

   assign timeout_o = tmo_q;
`else
   assign unused_timeout = ^timeout_cycles_i;
   assign timeout_o      = 1'b0;
`endif

   assign gnt_o     = req_i;
   assign rvalid_o  = rvalid_q;
   assign rdata_o   = rdata_q;
   assign err_o     = err_q;
   assign ch_done_o = done_q;
   assign eoc_o     = eoc_q;
   assign pass_o    = pass_q;
   assign fail_o    = fail_q;
   assign irq_o     = irq_q;

endmodule
